// File: rtl/mux4_rr_arbiter.sv
// Round-robin req/gnt arbiter driving a shared 4-way mux, with tenures capped at BURST_MAX transfers.
// Optional build macro MUX4_ARB_PRIO_EN: requester 0 wins every winner search (no mid-tenure preemption).
module mux4_rr_arbiter #(
  parameter int unsigned WIDTH     = 1,
  parameter int unsigned BURST_MAX = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic             out_ready,
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out
);

  localparam int unsigned     CW        = $clog2(BURST_MAX + 1);
  localparam logic [CW-1:0]   LAST_BEAT = CW'(BURST_MAX - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state, state_nxt;
  logic [3:0]    gnt_nxt;
  logic [1:0]    sel_nxt;
  logic [1:0]    last_ptr, last_ptr_nxt;
  logic [CW-1:0] beat_cnt, beat_nxt;
  logic [1:0]    winner, idx;
  logic          found;
  logic          any_req, transfer, rel;

  assign any_req  = |req;
  assign transfer = out_valid & out_ready;
  assign rel      = !req[sel] || (transfer && (beat_cnt == LAST_BEAT));

  // Scan from last_ptr+1 with wrap; offset 4 lands on last_ptr so the owner is considered last.
  always_comb begin
    winner = last_ptr;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned i = 1; i <= 4; i++) begin
      idx = last_ptr + 2'(i);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
`ifdef MUX4_ARB_PRIO_EN
    if (req[0]) winner = 2'd0;
`else
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= '0;
      sel      <= 2'b00;
      last_ptr <= 2'd3;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      sel      <= sel_nxt;
      last_ptr <= last_ptr_nxt;
      beat_cnt <= beat_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    gnt_nxt      = gnt;
    sel_nxt      = sel;
    last_ptr_nxt = last_ptr;
    beat_nxt     = beat_cnt;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt    = GRANT;
          gnt_nxt      = 4'b0001 << winner;
          sel_nxt      = winner;
          last_ptr_nxt = winner;
          beat_nxt     = '0;
        end
      end
      GRANT: begin
        // Release hands straight over to the next winner, so there is no idle bubble.
        if (rel) begin
          if (any_req) begin
            gnt_nxt      = 4'b0001 << winner;
            sel_nxt      = winner;
            last_ptr_nxt = winner;
            beat_nxt     = '0;
          end else begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
            beat_nxt  = '0;
          end
        end else if (transfer) begin
          beat_nxt = beat_cnt + CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    out_valid = gnt[sel] & req[sel];
    case (sel)
      2'd0:    out = in0;
      2'd1:    out = in1;
      2'd2:    out = in2;
      default: out = in3;
    endcase
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed self-checking bench for mux4_rr_arbiter (WIDTH=1, BURST_MAX=4).
module tb_mux4_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [0:0] in0, in1, in2, in3;
  logic       out_ready;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       out_valid;
  logic [0:0] out;

  int n_checks = 0;
  int n_pass   = 0;

  mux4_rr_arbiter #(.WIDTH(1), .BURST_MAX(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .in0       (in0),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .out_ready (out_ready),
    .gnt       (gnt),
    .sel       (sel),
    .out_valid (out_valid),
    .out       (out)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    req   = 4'b0000;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req = 4'b1111;
    out_ready = 1'b0;
    tick();
    tick();
    n_checks++;
    if (gnt !== 4'b0000 || sel !== 2'b00 || out_valid !== 1'b0)
      $display("FAIL reset gnt=%b sel=%b vld=%b exp gnt=0000 sel=00 vld=0", gnt, sel, out_valid);
    else n_pass++;
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (gnt !== 4'b0001 || sel !== 2'b00)
      $display("FAIL reset_first_gnt gnt=%b sel=%b exp gnt=0001 sel=00", gnt, sel);
    else n_pass++;
  endtask

  // Continues from test_reset: req=1111, owner 0 just granted.
  task automatic test_rotation;
    int unsigned owners [5] = '{0, 1, 2, 3, 0};
    logic [3:0] exp_gnt;
    logic [0:0] exp_out;
    in0 = 1'b1; in1 = 1'b0; in2 = 1'b1; in3 = 1'b0;
    out_ready = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      exp_gnt = 4'b0001 << owners[k];
      exp_out = (owners[k] % 2 == 0) ? 1'b1 : 1'b0;
      for (int c = 0; c < 4; c++) begin
        n_checks++;
        if (gnt !== exp_gnt || sel !== 2'(owners[k]) || out !== exp_out || out_valid !== 1'b1)
          $display("FAIL rotation k=%0d c=%0d gnt=%b sel=%0d out=%b vld=%b exp gnt=%b sel=%0d out=%b vld=1",
                   k, c, gnt, sel, out, out_valid, exp_gnt, owners[k], exp_out);
        else n_pass++;
        tick();
      end
    end
  endtask

  task automatic test_backpressure;
    do_reset();
    req = 4'b0100;
    out_ready = 1'b0;
    tick();
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if (gnt !== 4'b0100 || dut.beat_cnt !== 3'd0 || out_valid !== 1'b1)
        $display("FAIL backpressure_hold c=%0d gnt=%b beat=%0d vld=%b exp gnt=0100 beat=0 vld=1",
                 c, gnt, dut.beat_cnt, out_valid);
      else n_pass++;
      tick();
    end
    out_ready = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      n_checks++;
      if (gnt !== 4'b0100 || dut.beat_cnt !== 3'(c % 4))
        $display("FAIL backpressure_xfer c=%0d gnt=%b beat=%0d exp gnt=0100 beat=%0d",
                 c, gnt, dut.beat_cnt, c % 4);
      else n_pass++;
    end
  endtask

  task automatic test_early_drop;
    do_reset();
    req = 4'b1010;
    out_ready = 1'b1;
    tick();
    n_checks++;
    if (gnt !== 4'b0010 || sel !== 2'd1)
      $display("FAIL early_drop_grant gnt=%b sel=%0d exp gnt=0010 sel=1", gnt, sel);
    else n_pass++;
    tick();
    tick();
    req = 4'b1000;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || gnt !== 4'b0010)
      $display("FAIL early_drop_vld vld=%b gnt=%b exp vld=0 gnt=0010", out_valid, gnt);
    else n_pass++;
    tick();
    n_checks++;
    if (gnt !== 4'b1000 || sel !== 2'd3)
      $display("FAIL early_drop_switch gnt=%b sel=%0d exp gnt=1000 sel=3", gnt, sel);
    else n_pass++;
  endtask

  // Continues from test_early_drop: owner 3 holds the grant.
  task automatic test_idle_sole;
    req = 4'b0000;
    tick();
    n_checks++;
    if (gnt !== 4'b0000 || sel !== 2'd3 || out_valid !== 1'b0)
      $display("FAIL idle gnt=%b sel=%0d vld=%b exp gnt=0000 sel=3 vld=0", gnt, sel, out_valid);
    else n_pass++;
    tick();
    n_checks++;
    if (gnt !== 4'b0000 || sel !== 2'd3)
      $display("FAIL idle_hold gnt=%b sel=%0d exp gnt=0000 sel=3", gnt, sel);
    else n_pass++;
    req = 4'b0010;
    tick();
    n_checks++;
    if (gnt !== 4'b0010 || sel !== 2'd1)
      $display("FAIL sole_grant gnt=%b sel=%0d exp gnt=0010 sel=1", gnt, sel);
    else n_pass++;
    for (int c = 1; c <= 9; c++) begin
      tick();
      n_checks++;
      if (gnt !== 4'b0010 || dut.beat_cnt !== 3'(c % 4))
        $display("FAIL sole_regrant c=%0d gnt=%b beat=%0d exp gnt=0010 beat=%0d",
                 c, gnt, dut.beat_cnt, c % 4);
      else n_pass++;
    end
  endtask

  task automatic test_no_preempt;
    logic [3:0] exp_next;
    do_reset();
    req = 4'b0100;
    out_ready = 1'b1;
    tick();
    n_checks++;
    if (gnt !== 4'b0100)
      $display("FAIL preempt_grant gnt=%b exp 0100", gnt);
    else n_pass++;
    tick();
    req = 4'b1101;
    tick();
    tick();
    n_checks++;
    if (gnt !== 4'b0100 || dut.beat_cnt !== 3'd3)
      $display("FAIL preempt_hold gnt=%b beat=%0d exp gnt=0100 beat=3", gnt, dut.beat_cnt);
    else n_pass++;
    tick();
`ifdef MUX4_ARB_PRIO_EN
    exp_next = 4'b0001;
`else
    exp_next = 4'b1000;
`endif
    n_checks++;
    if (gnt !== exp_next)
      $display("FAIL preempt_next gnt=%b exp %b", gnt, exp_next);
    else n_pass++;
`ifdef MUX4_ARB_PRIO_EN
    req = 4'b1000;
    exp_next = 4'b1000;
`else
    req = 4'b0001;
    exp_next = 4'b0001;
`endif
    tick();
    n_checks++;
    if (gnt !== exp_next)
      $display("FAIL preempt_after gnt=%b exp %b", gnt, exp_next);
    else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0;
    req = 4'b0000;
    in0 = 1'b0; in1 = 1'b0; in2 = 1'b0; in3 = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_rotation();
    test_backpressure();
    test_early_drop();
    test_idle_sole();
    test_no_preempt();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
